// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC/HOLD loop with jump/branch
// next-PC selection, fetch timeout into an absorbing ERR state, and a sticky fetch_err flag.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  JumpOP,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jr_target,
    input  logic [25:0] jump_index,
    input  logic        stall,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        instr_valid,
    output logic        redirect,
    output logic        misalign,
    output logic        fetch_err,
    output logic [2:0]  state_dbg
);

    // Handshake: imem_req stays high for every FETCH cycle until imem_ack is seen;
    // imem_ack in any other state is ignored.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = FETCH_TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] next_pc;
    logic [7:0]  cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            cnt_q       <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        link_addr = pc_q + 32'd4;
        cnt_inc   = cnt_q + 8'd1;
        case (JumpOP)
            2'd1:    next_pc = link_addr + (branch_offset << 2);
            2'd2:    next_pc = {jr_target[31:2], 2'b00};
            2'd3:    next_pc = {link_addr[31:28], jump_index, 2'b00};
            default: next_pc = link_addr;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        redirect    = 1'b0;
        misalign    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = 8'd0;
            end
            FETCH: begin
                imem_req = 1'b1;
                // An ack in the timeout cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIM) begin
                        state_d     = ERR;
                        fetch_err_d = 1'b1;
                    end
                end
            end
            EXEC, HOLD: begin
                instr_valid = 1'b1;
                if (stall) begin
                    state_d = HOLD;
                end else begin
                    pc_d     = next_pc;
                    state_d  = FETCH;
                    cnt_d    = 8'd0;
                    redirect = (JumpOP != 2'd0);
                    misalign = (JumpOP == 2'd2) && (jr_target[1:0] != 2'b00);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset cycle discards any pending update, so its pulses are suppressed too.
        if (rst) begin
            redirect = 1'b0;
            misalign = 1'b0;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign fetch_err = fetch_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: per-cycle vectors on a default instance,
// plus hand-written timeout/error sequences on an instance with FETCH_TIMEOUT=4.
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic [1:0]  jop;
        logic [31:0] boff;
        logic [31:0] jrt;
        logic [25:0] jidx;
        logic [2:0]  e_st;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_iv;
        logic        e_red;
        logic        e_mis;
        logic        e_ferr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  jump_op;
    logic [31:0] branch_offset;
    logic [31:0] jr_target;
    logic [25:0] jump_index;
    logic        stall;
    logic        imem_ack;

    logic        a_req, a_iv, a_red, a_mis, a_ferr;
    logic [31:0] a_addr, a_pc, a_link;
    logic [2:0]  a_st;
    logic        b_req, b_iv, b_red, b_mis, b_ferr;
    logic [31:0] b_addr, b_pc, b_link;
    logic [2:0]  b_st;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_sequencer u_dut_a (
        .clk(clk), .rst(rst), .JumpOP(jump_op), .branch_offset(branch_offset),
        .jr_target(jr_target), .jump_index(jump_index), .stall(stall), .imem_ack(imem_ack),
        .imem_req(a_req), .imem_addr(a_addr), .pc(a_pc), .link_addr(a_link),
        .instr_valid(a_iv), .redirect(a_red), .misalign(a_mis), .fetch_err(a_ferr),
        .state_dbg(a_st)
    );

    pc_sequencer #(.RESET_PC(32'h0000_1000), .FETCH_TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .JumpOP(jump_op), .branch_offset(branch_offset),
        .jr_target(jr_target), .jump_index(jump_index), .stall(stall), .imem_ack(imem_ack),
        .imem_req(b_req), .imem_addr(b_addr), .pc(b_pc), .link_addr(b_link),
        .instr_valid(b_iv), .redirect(b_red), .misalign(b_mis), .fetch_err(b_ferr),
        .state_dbg(b_st)
    );

    function automatic vec_t mk(logic r, logic a, logic s, logic [1:0] j, logic [31:0] bo,
                                logic [31:0] jr, logic [25:0] ji, logic [2:0] st,
                                logic [31:0] p, logic rq, logic iv, logic rd, logic ms,
                                logic fe);
        vec_t v;
        v.rst = r; v.ack = a; v.stall = s; v.jop = j; v.boff = bo; v.jrt = jr; v.jidx = ji;
        v.e_st = st; v.e_pc = p; v.e_req = rq; v.e_iv = iv; v.e_red = rd; v.e_mis = ms;
        v.e_ferr = fe;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit later, well away from the rising edge.
    task automatic run_vec(input vec_t v, input int idx, input bit use_b);
        @(negedge clk);
        rst = v.rst; imem_ack = v.ack; stall = v.stall; jump_op = v.jop;
        branch_offset = v.boff; jr_target = v.jrt; jump_index = v.jidx;
        #1;
        if (!use_b) begin
            chk("state", idx, {29'd0, a_st}, {29'd0, v.e_st});
            chk("pc", idx, a_pc, v.e_pc);
            chk("imem_addr", idx, a_addr, v.e_pc);
            chk("link_addr", idx, a_link, v.e_pc + 32'd4);
            chk("imem_req", idx, {31'd0, a_req}, {31'd0, v.e_req});
            chk("instr_valid", idx, {31'd0, a_iv}, {31'd0, v.e_iv});
            chk("redirect", idx, {31'd0, a_red}, {31'd0, v.e_red});
            chk("misalign", idx, {31'd0, a_mis}, {31'd0, v.e_mis});
            chk("fetch_err", idx, {31'd0, a_ferr}, {31'd0, v.e_ferr});
        end else begin
            chk("b_state", idx, {29'd0, b_st}, {29'd0, v.e_st});
            chk("b_pc", idx, b_pc, v.e_pc);
            chk("b_imem_addr", idx, b_addr, v.e_pc);
            chk("b_imem_req", idx, {31'd0, b_req}, {31'd0, v.e_req});
            chk("b_instr_valid", idx, {31'd0, b_iv}, {31'd0, v.e_iv});
            chk("b_redirect", idx, {31'd0, b_red}, {31'd0, v.e_red});
            chk("b_fetch_err", idx, {31'd0, b_ferr}, {31'd0, v.e_ferr});
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; jump_op = 2'd0;
            branch_offset = 32'd0; jr_target = 32'd0; jump_index = 26'd0;
        end
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; jump_op = 2'd0;
        branch_offset = 32'd0; jr_target = 32'd0; jump_index = 26'd0;

        //                r  a  s  jop  boff           jrt            jidx          state    pc             rq iv rd ms fe
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_IDLE,  32'h0,         0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h0,         0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h4,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h4,         0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h8,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h8,         0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'hC,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'hC,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd2, 32'd0,        32'h100,       26'd0,        S_EXEC,  32'hC,         0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h100,       1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd1, 32'hFFFF_FFFE, 32'd0,        26'd0,        S_EXEC,  32'h100,       0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'hFC,        1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd2, 32'd0,        32'h203,       26'd0,        S_EXEC,  32'hFC,        0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h200,       1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd3, 32'd0,        32'd0,         26'h10_0004,  S_EXEC,  32'h200,       0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0040_0010, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd3, 32'd0,        32'd0,         26'h10_0000,  S_EXEC,  32'h0040_0010, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0040_0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h0040_0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd0, 32'd0,        32'd0,         26'd0,        S_HOLD,  32'h0040_0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd3, 32'd0,        32'd0,         26'h3FF_FFFF, S_HOLD,  32'h0040_0000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd3, 32'd0,        32'd0,         26'h40,       S_HOLD,  32'h0040_0000, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h100,       1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd2, 32'd0,        32'hFFFF_FFFF, 26'd0,        S_EXEC,  32'h100,       0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'hFFFF_FFFC, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'hFFFF_FFFC, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h0,         0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h4,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h4,         0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2'd3, 32'd0,        32'd0,         26'h40,       S_HOLD,  32'h4,         0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_IDLE,  32'h0,         0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_IDLE,  32'h0,         0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_FETCH, 32'h0,         1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'd0,        32'd0,         26'd0,        S_EXEC,  32'h0,         0, 1, 0, 0, 0));

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i], i, 1'b0);

        // Timeout instance: ack in the 4th FETCH cycle wins, then a real timeout into ERR.
        do_reset();
        run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0, S_IDLE,  32'h1000, 0, 0, 0, 0, 0), 100, 1'b1);
        for (int i = 0; i < 3; i++)
            run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0, S_FETCH, 32'h1000, 1, 0, 0, 0, 0), 101 + i, 1'b1);
        run_vec(mk(0, 1, 0, 2'd0, 32'd0, 32'd0, 26'd0, S_FETCH, 32'h1000, 1, 0, 0, 0, 0), 104, 1'b1);
        run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0, S_EXEC,  32'h1000, 0, 1, 0, 0, 0), 105, 1'b1);
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0, S_FETCH, 32'h1004, 1, 0, 0, 0, 0), 106 + i, 1'b1);
        run_vec(mk(0, 1, 0, 2'd0, 32'd0, 32'd0, 26'd0,  S_ERR,  32'h1004, 0, 0, 0, 0, 1), 110, 1'b1);
        run_vec(mk(0, 1, 0, 2'd3, 32'd0, 32'd0, 26'h40, S_ERR,  32'h1004, 0, 0, 0, 0, 1), 111, 1'b1);
        run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0,  S_ERR,  32'h1004, 0, 0, 0, 0, 1), 112, 1'b1);
        run_vec(mk(1, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0,  S_ERR,  32'h1004, 0, 0, 0, 0, 1), 113, 1'b1);
        run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0,  S_IDLE, 32'h1000, 0, 0, 0, 0, 0), 114, 1'b1);
        run_vec(mk(0, 0, 0, 2'd0, 32'd0, 32'd0, 26'd0,  S_FETCH, 32'h1000, 1, 0, 0, 0, 0), 115, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 255, max cycles in FETCH without imem_ack before error; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 JumpOP  input  2  next-PC select from jump control: 0 sequential, 1 branch taken, 2 register jump (jr/jalr), 3 absolute jump (j/jal).
REQ-006 branch_offset  input  32  sign-extended branch immediate in words.
REQ-007 jr_target  input  32  register-jump target byte address.
REQ-008 jump_index  input  26  j/jal instruction index field.
REQ-009 stall  input  1  hold current instruction in execute; PC update deferred.
REQ-010 imem_ack  input  1  instruction memory returns data for current imem_addr.
REQ-011 imem_req  output  1  fetch request, held until acked.
REQ-012 imem_addr  output  32  fetch address, always equal to pc.
REQ-013 pc  output  32  address of instruction being fetched/executed.
REQ-014 link_addr  output  32  pc+4, combinational, for jal/jalr writeback.
REQ-015 instr_valid  output  1  high while the fetched instruction is in execute (EXEC or HOLD).
REQ-016 redirect  output  1  one-cycle pulse when the PC update is non-sequential (JumpOP!=0).
REQ-017 misalign  output  1  one-cycle pulse when a JumpOP=2 update has jr_target[1:0]!=0.
REQ-018 fetch_err  output  1  sticky, set on fetch timeout, cleared only by rst.

Function
REQ-019 States SHALL be IDLE, FETCH, EXEC, HOLD, ERR; encoding free.
REQ-020 IDLE -> FETCH unconditionally on the next cycle.
REQ-021 FETCH: imem_req=1; on imem_ack -> EXEC; timeout counter cleared on FETCH entry, incremented each FETCH cycle without ack.
REQ-022 FETCH with counter reaching FETCH_TIMEOUT and no ack -> ERR; set fetch_err; imem_req=0.
REQ-023 ack and timeout in the same cycle: ack wins, -> EXEC, fetch_err unchanged.
REQ-024 EXEC: instr_valid=1; stall=1 -> HOLD with pc unchanged; stall=0 -> pc<=next_pc, -> FETCH.
REQ-025 HOLD: instr_valid=1, imem_req=0; stall=0 -> pc<=next_pc sampled that cycle, -> FETCH; JumpOP, branch_offset, jr_target, jump_index sampled only in the update cycle.
REQ-026 next_pc: JumpOP=0 -> pc+4; 1 -> pc+4+(branch_offset<<2); 2 -> {jr_target[31:2],2'b00}; 3 -> {link_addr[31:28],jump_index,2'b00}.
REQ-027 All PC arithmetic 32-bit modulo 2^32; overflow/wrap silent (pc=32'hFFFF_FFFC, JumpOP=0 -> 32'h0).
REQ-028 redirect and misalign SHALL assert only in the cycle pc is updated, zero otherwise.
REQ-029 ERR: absorbing; imem_req=0, instr_valid=0, pc frozen.
REQ-030 Latency: minimum 2 cycles per instruction (FETCH with immediate ack, EXEC).
REQ-031 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-032 rst=1 overrides all inputs in any state: next cycle state=IDLE, pc=RESET_PC, counter=0, fetch_err=0, imem_req=0, instr_valid=0, redirect=0, misalign=0.
REQ-033 rst mid-fetch or in HOLD discards the pending instruction; no PC update occurs.

Verification
REQ-034 Reset then imem_ack tied 1, JumpOP=0 -> pc sequence 0,4,8,... changing every 2 cycles, redirect never high.
REQ-035 pc=0x100 in EXEC, JumpOP=1, branch_offset=32'hFFFF_FFFE -> pc=0xFC, redirect pulse 1 cycle.
REQ-036 pc=0x0040_0010, JumpOP=3, jump_index=26'h10_0000 -> pc=0x0040_0000; JumpOP=2, jr_target=0x203 -> pc=0x200, misalign pulse.
REQ-037 EXEC with stall=1 for 3 cycles, JumpOP changed 0->3 in last cycle -> pc held 4 cycles, updated per value at stall release.
REQ-038 FETCH_TIMEOUT=4, imem_ack held 0 -> ERR after 4 FETCH cycles, fetch_err=1 sticky; rst -> pc=RESET_PC, fetch_err=0.
